// File: rtl/tage_update_queue_pkg.sv
// Shared definitions for the TAGE update path: security domains, the queued
// update record and the drain-sequencer state encoding.
package tage_update_queue_pkg;

  localparam int UPD_IDX_W  = 32;
  localparam int UPD_TARG_W = 32;

  typedef enum logic [1:0] {
    DOM_USER       = 2'd0,
    DOM_SUPERVISOR = 2'd1,
    DOM_HYPERVISOR = 2'd2,
    DOM_MACHINE    = 2'd3
  } domain_t;

  // One resolved branch waiting to train the predictor.
  typedef struct packed {
    logic [UPD_IDX_W-1:0]  idx;
    logic                  taken;
    logic                  correct;
    domain_t               domain;
    logic [UPD_TARG_W-1:0] targ;
  } upd_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } uq_state_t;

endpackage

// File: rtl/tage_update_queue_if.sv
// Bundle between execute-side resolution, the update queue and the TAGE
// update port. The slave modport is the queue's view.
//
// Handshakes: a resolved branch transfers on a cycle where res_valid_i and
// res_ready_o are both high; an update transfers on a cycle where update_en_o
// is high and upd_hold_i is low. While a transfer is stalled the offering
// side keeps its payload stable.
interface tage_update_queue_if
  import tage_update_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = UPD_IDX_W,
  parameter int TARG_W = UPD_TARG_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              res_valid_i;
  logic              res_ready_o;
  logic [IDX_W-1:0]  res_idx_i;
  logic              res_taken_i;
  logic              res_pred_i;
  domain_t           res_domain_i;
  logic [TARG_W-1:0] res_targ_i;

  logic              update_en_o;
  logic              br_result_o;
  logic              correct_o;
  logic [IDX_W-1:0]  idx_o;
  domain_t           domain_o;
  logic [TARG_W-1:0] targ_o;
  logic              upd_hold_i;

  logic              flush_i;
  logic              drain_req_i;
  logic              drain_done_o;
  logic [CNT_W-1:0]  count_o;
  uq_state_t         dbg_state;

  modport slave (
    input  res_valid_i, res_idx_i, res_taken_i, res_pred_i, res_domain_i,
           res_targ_i, upd_hold_i, flush_i, drain_req_i,
    output res_ready_o, update_en_o, br_result_o, correct_o, idx_o,
           domain_o, targ_o, drain_done_o, count_o, dbg_state
  );

  modport master (
    output res_valid_i, res_idx_i, res_taken_i, res_pred_i, res_domain_i,
           res_targ_i, upd_hold_i, flush_i, drain_req_i,
    input  res_ready_o, update_en_o, br_result_o, correct_o, idx_o,
           domain_o, targ_o, drain_done_o, count_o, dbg_state
  );

endinterface

// File: rtl/tage_upd_fifo.sv
// Circular buffer of pending updates. Flush dominates push/pop and rewinds
// both pointers. Head reads as zero when empty so the update bus is quiet.
module tage_upd_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  entry_t                     wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;

  // Payload storage; contents are only observed while the entry is live.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wr_ptr] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth wraps for free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = (count_q != '0) ? mem[rd_ptr] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/tage_update_queue.sv
// Update queue in front of the TAGE predictor: buffers resolved branches,
// issues one update per cycle, and sequences a drain before domain switches.
module tage_update_queue
  import tage_update_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = UPD_IDX_W,
  parameter int TARG_W = UPD_TARG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  tage_update_queue_if.slave bus
);
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  uq_state_t        state_q;
  logic             done_q;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  upd_entry_t       wdata;
  upd_entry_t       head;

  // A full queue refuses offers even when it pops in the same cycle, which
  // keeps the ready path independent of upd_hold_i.
  assign bus.res_ready_o = rst_ni && (state_q == ST_RUN) && (count < FULL_CNT)
                           && !bus.flush_i;
  assign bus.update_en_o = (count != '0) && !bus.flush_i;
  assign push            = bus.res_valid_i && bus.res_ready_o;
  assign pop             = bus.update_en_o && !bus.upd_hold_i;

  // Training record: correctness is fixed at resolution time.
  always_comb begin
    wdata         = '0;
    wdata.idx     = bus.res_idx_i;
    wdata.taken   = bus.res_taken_i;
    wdata.correct = (bus.res_pred_i == bus.res_taken_i);
    wdata.domain  = bus.res_domain_i;
    wdata.targ    = bus.res_targ_i;
  end

  tage_upd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (upd_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .flush_i (bus.flush_i),
    .head_o  (head),
    .count_o (count)
  );

  // Drain sequencer: stop intake, wait for empty (or flush), pulse done once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (bus.drain_req_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.flush_i || (count == '0)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_RUN;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.br_result_o  = head.taken;
  assign bus.correct_o    = head.correct;
  assign bus.idx_o        = head.idx;
  assign bus.domain_o     = head.domain;
  assign bus.targ_o       = head.targ;
  assign bus.drain_done_o = done_q;
  assign bus.count_o      = count;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_tage_update_queue.sv
// Bench for tage_update_queue: vector table, directed corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_tage_update_queue;
  import tage_update_queue_pkg::*;

  localparam int DEPTH  = 4;
  localparam int IDX_W  = 32;
  localparam int TARG_W = 32;
  localparam int EW     = $bits(upd_entry_t);

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE  = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tage_update_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TARG_W(TARG_W)) bus();

  tage_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TARG_W(TARG_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int              checks   = 0;
  int              failures = 0;
  logic [EW-1:0]   exp_q[$];
  int              m_mode   = M_RUN;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the model's queue contents and mode.
  task automatic check_outputs();
    upd_entry_t h;
    logic       e_ready;
    logic       e_upd;
    h       = (exp_q.size() != 0) ? upd_entry_t'(exp_q[0]) : '0;
    e_ready = rst_n && (m_mode == M_RUN) && (exp_q.size() < DEPTH) && !bus.flush_i;
    e_upd   = (exp_q.size() != 0) && !bus.flush_i;
    chk("res_ready", 64'(bus.res_ready_o), 64'(e_ready));
    chk("update_en", 64'(bus.update_en_o), 64'(e_upd));
    chk("idx",       64'(bus.idx_o), 64'(h.idx));
    chk("targ",      64'(bus.targ_o), 64'(h.targ));
    chk("domain",    64'(bus.domain_o), 64'(h.domain));
    chk("br_result", 64'(bus.br_result_o), 64'(h.taken));
    chk("correct",   64'(bus.correct_o), 64'(h.correct));
    chk("count",     64'(bus.count_o), 64'(exp_q.size()));
    chk("drain_done", 64'(bus.drain_done_o), 64'(m_mode == M_DONE));
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    int         sz;
    bit         do_push;
    bit         do_pop;
    upd_entry_t e;
    sz      = exp_q.size();
    do_push = bus.res_valid_i && (m_mode == M_RUN) && (sz < DEPTH) && !bus.flush_i;
    do_pop  = (sz != 0) && !bus.flush_i && !bus.upd_hold_i;
    e         = '0;
    e.idx     = bus.res_idx_i;
    e.taken   = bus.res_taken_i;
    e.correct = (bus.res_pred_i == bus.res_taken_i);
    e.domain  = bus.res_domain_i;
    e.targ    = bus.res_targ_i;
    if (m_mode == M_RUN) begin
      if (bus.drain_req_i) m_mode = M_DRAIN;
    end else if (m_mode == M_DRAIN) begin
      if (sz == 0 || bus.flush_i) m_mode = M_DONE;
    end else begin
      m_mode = M_RUN;
    end
    if (bus.flush_i) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(EW'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.res_valid_i  = 1'b0;
    bus.res_idx_i    = '0;
    bus.res_taken_i  = 1'b0;
    bus.res_pred_i   = 1'b0;
    bus.res_domain_i = DOM_USER;
    bus.res_targ_i   = '0;
    bus.upd_hold_i   = 1'b0;
    bus.flush_i      = 1'b0;
    bus.drain_req_i  = 1'b0;
  endtask

  task automatic set_res(input logic v, input logic [31:0] idx, input logic taken,
                         input logic pred, input logic [1:0] dom, input logic [31:0] targ);
    bus.res_valid_i  = v;
    bus.res_idx_i    = idx;
    bus.res_taken_i  = taken;
    bus.res_pred_i   = pred;
    bus.res_domain_i = domain_t'(dom);
    bus.res_targ_i   = targ;
  endtask

  // Called 1 time unit after a falling edge: check, step model, next cycle.
  task automatic finish_cycle();
    check_outputs();
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle();
    #1;
    finish_cycle();
  endtask

  task automatic fill_held(input int n, input logic [31:0] base);
    bus.upd_hold_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      set_res(1'b1, base + 32'(k), 1'(k), 1'b1, 2'(k), 32'hA000 + 32'(k));
      cycle();
    end
    bus.res_valid_i = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] idx;
    logic        taken;
    logic        pred;
    logic [1:0]  dom;
    logic [31:0] targ;
    logic        exp_correct;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n_upd;
    bit seen;

    vecs[0] = '{32'h0000_0040, 1'b1, 1'b0, 2'd0, 32'h0000_1000, 1'b0};
    vecs[1] = '{32'h0000_0044, 1'b0, 1'b0, 2'd1, 32'h0000_2000, 1'b1};
    vecs[2] = '{32'h0000_0048, 1'b1, 1'b1, 2'd2, 32'h0000_3000, 1'b1};
    vecs[3] = '{32'h0000_004C, 1'b0, 1'b1, 2'd3, 32'h0000_4000, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h0000_0000, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 1'b1};

    // reset
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    chk("reset_ready", 64'(bus.res_ready_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: single push, one-cycle latency, then idle
    for (int i = 0; i < 6; i++) begin
      set_res(1'b1, vecs[i].idx, vecs[i].taken, vecs[i].pred, vecs[i].dom, vecs[i].targ);
      cycle();
      idle_inputs();
      #1;
      chk("vec_update_en", 64'(bus.update_en_o), 64'd1);
      chk("vec_idx",       64'(bus.idx_o), 64'(vecs[i].idx));
      chk("vec_br_result", 64'(bus.br_result_o), 64'(vecs[i].taken));
      chk("vec_correct",   64'(bus.correct_o), 64'(vecs[i].exp_correct));
      chk("vec_domain",    64'(bus.domain_o), 64'(vecs[i].dom));
      chk("vec_targ",      64'(bus.targ_o), 64'(vecs[i].targ));
      finish_cycle();
      #1;
      chk("vec_update_after", 64'(bus.update_en_o), 64'd0);
      finish_cycle();
    end

    // fill under hold, refuse fifth, then one-per-cycle in order
    fill_held(4, 32'h100);
    set_res(1'b1, 32'h1FF, 1'b1, 1'b1, 2'd0, 32'h0);
    #1;
    chk("full_count", 64'(bus.count_o), 64'd4);
    chk("full_ready", 64'(bus.res_ready_o), 64'd0);
    finish_cycle();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stream_en",    64'(bus.update_en_o), 64'd1);
      chk("stream_idx",   64'(bus.idx_o), 64'(32'h100 + 32'(k)));
      chk("stream_count", 64'(bus.count_o), 64'(4 - k));
      finish_cycle();
    end
    #1;
    chk("stream_empty", 64'(bus.count_o), 64'd0);
    finish_cycle();

    // full with pop: push refused this cycle, accepted next
    fill_held(4, 32'h200);
    bus.upd_hold_i = 1'b0;
    set_res(1'b1, 32'h2FF, 1'b0, 1'b0, 2'd1, 32'hBEEF);
    #1;
    chk("fullpop_ready", 64'(bus.res_ready_o), 64'd0);
    chk("fullpop_en",    64'(bus.update_en_o), 64'd1);
    finish_cycle();
    #1;
    chk("fullpop_ready_next", 64'(bus.res_ready_o), 64'd1);
    finish_cycle();
    idle_inputs();
    repeat (6) cycle();

    // drain with three entries
    fill_held(3, 32'h300);
    bus.upd_hold_i  = 1'b0;
    bus.drain_req_i = 1'b1;
    n_upd = 0;
    seen  = 0;
    #1;
    if (bus.update_en_o && !bus.upd_hold_i) n_upd++;
    finish_cycle();
    bus.drain_req_i = 1'b0;
    #1;
    chk("drain_ready", 64'(bus.res_ready_o), 64'd0);
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k != 0) #1;
      if (bus.update_en_o && !bus.upd_hold_i) n_upd++;
      if (bus.drain_done_o) seen = 1;
      finish_cycle();
    end
    chk("drain_done_seen", 64'(seen), 64'd1);
    chk("drain_updates",   64'(n_upd), 64'd3);
    #1;
    chk("drain_done_once", 64'(bus.drain_done_o), 64'd0);
    chk("drain_back_run",  64'(bus.dbg_state), 64'(ST_RUN));
    chk("drain_ready_run", 64'(bus.res_ready_o), 64'd1);
    finish_cycle();

    // drain while empty: done two cycles after request
    bus.drain_req_i = 1'b1;
    cycle();
    bus.drain_req_i = 1'b0;
    #1;
    chk("edrain_done_early", 64'(bus.drain_done_o), 64'd0);
    finish_cycle();
    #1;
    chk("edrain_done", 64'(bus.drain_done_o), 64'd1);
    finish_cycle();
    cycle();

    // flush with three entries and an offer
    fill_held(3, 32'h400);
    bus.upd_hold_i = 1'b0;
    bus.flush_i    = 1'b1;
    set_res(1'b1, 32'h4FF, 1'b1, 1'b0, 2'd2, 32'h1);
    #1;
    chk("flush_en",    64'(bus.update_en_o), 64'd0);
    chk("flush_ready", 64'(bus.res_ready_o), 64'd0);
    finish_cycle();
    idle_inputs();
    #1;
    chk("flush_count", 64'(bus.count_o), 64'd0);
    chk("flush_en_next", 64'(bus.update_en_o), 64'd0);
    finish_cycle();

    // reset in the middle of a drain
    fill_held(2, 32'h500);
    bus.drain_req_i = 1'b1;
    cycle();
    bus.drain_req_i = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_en",     64'(bus.update_en_o), 64'd0);
    chk("rst_count",  64'(bus.count_o), 64'd0);
    chk("rst_idx",    64'(bus.idx_o), 64'd0);
    chk("rst_targ",   64'(bus.targ_o), 64'd0);
    chk("rst_result", 64'(bus.br_result_o), 64'd0);
    chk("rst_done",   64'(bus.drain_done_o), 64'd0);
    chk("rst_ready",  64'(bus.res_ready_o), 64'd0);
    exp_q.delete();
    m_mode = M_RUN;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("rst_ready_after", 64'(bus.res_ready_o), 64'd1);
    finish_cycle();
    repeat (4) cycle();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      set_res(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      bus.upd_hold_i  = ($urandom_range(0, 2) == 0);
      bus.flush_i     = ($urandom_range(0, 40) == 0);
      bus.drain_req_i = ($urandom_range(0, 30) == 0);
      cycle();
    end
    idle_inputs();
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
